// File: rtl/jk_excite_driver.sv
// jk_excite_driver
//
// Drives an external JK flip-flop toward a stream of target bits. Targets are
// queued in a small FIFO. Each item is popped into a holding register, the J/K
// excitation needed to move the flop from its present Q to the target is
// registered onto J/K for one DRIVE cycle, and the flop's Q is checked against
// the target on the closing edge of the following CHECK cycle. Back-to-back
// items run at one per two cycles.
//
// Parameters
//   DEPTH   FIFO entries (power of 2, >= 2)
//   CNT_W   width of ERR_CNT / DONE_CNT
//   DC_ONE  value driven on the excitation input that does not matter
//
// Ports
//   CLK        rising-edge clock
//   RESET_N    asynchronous active-low reset
//   CLR        synchronous clear, overrides push/pop/count on its edge
//   TGT_BIT    desired next Q of the driven flop
//   TGT_VALID  TGT_BIT valid
//   TGT_READY  FIFO not full
//   Q_FB       Q fed back from the driven flop
//   J, K       registered excitation
//   MISMATCH   one-cycle pulse after a CHECK whose Q differed from target
//   ERR_CNT    saturating mismatch count
//   DONE_CNT   saturating checked-item count
//   BUSY       FSM active or FIFO non-empty

module jk_excite_driver #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 8,
  parameter bit          DC_ONE = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CLR,
  input  logic             TGT_BIT,
  input  logic             TGT_VALID,
  output logic             TGT_READY,
  input  logic             Q_FB,
  output logic             J,
  output logic             K,
  output logic             MISMATCH,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] DONE_CNT,
  output logic             BUSY
);

  localparam int unsigned     AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     DepthCnt = DEPTH[AW:0];
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StCheck
  } state_e;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] fifo_q, fifo_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic             tgt_q, tgt_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             mm_q, mm_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] done_q, done_d;

  logic full, empty, push, pop, head, check_end;
  logic exc_j, exc_k;

  assign full      = (occ_q == DepthCnt);
  assign empty     = (occ_q == '0);
  assign TGT_READY = !full;
  assign push      = TGT_VALID && !full && !CLR;
  assign head      = fifo_q[rd_ptr_q];

  // Excitation from the present Q to the head target; the input that cannot
  // affect the transition is driven with DC_ONE.
  assign exc_j = Q_FB ? DC_ONE : head;
  assign exc_k = Q_FB ? !head  : DC_ONE;

  // Sequencer: pop whenever idle or finishing a check with work queued.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StDrive;
        end
      end
      StDrive: begin
        state_d = StCheck;
      end
      StCheck: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StDrive;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (CLR) begin
      state_d = StIdle;
      pop     = 1'b0;
    end
  end

  assign check_end = (state_q == StCheck) && !CLR;

  // Datapath next-state: J/K are only non-zero for the cycle after a pop.
  always_comb begin
    tgt_d  = tgt_q;
    j_d    = 1'b0;
    k_d    = 1'b0;
    mm_d   = 1'b0;
    err_d  = err_q;
    done_d = done_q;

    if (pop) begin
      tgt_d = head;
      j_d   = exc_j;
      k_d   = exc_k;
    end

    if (check_end) begin
      mm_d = (Q_FB != tgt_q);
      if (done_q != CntMax) begin
        done_d = done_q + 1'b1;
      end
      if (mm_d && (err_q != CntMax)) begin
        err_d = err_q + 1'b1;
      end
    end

    if (CLR) begin
      err_d  = '0;
      done_d = '0;
    end
  end

  // FIFO next-state.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;

    if (CLR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = TGT_BIT;
        wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= StIdle;
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      tgt_q    <= 1'b0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      mm_q     <= 1'b0;
      err_q    <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      tgt_q    <= tgt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      mm_q     <= mm_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign J        = j_q;
  assign K        = k_q;
  assign MISMATCH = mm_q;
  assign ERR_CNT  = err_q;
  assign DONE_CNT = done_q;
  assign BUSY     = (state_q != StIdle) || !empty;

endmodule

// File: doc/jk_excite_driver.md
JK_EXCITE_DRIVER -- requirements
Module: jk_excite_driver

Interface
REQ-001 The module SHALL have parameters, one per line:
  DEPTH    4   target FIFO entries, power of 2, >= 2
  CNT_W    8   width of ERR_CNT and DONE_CNT
  DC_ONE   0   value driven on don't-care excitation inputs (0 or 1)
REQ-002 The module SHALL have ports, one per line:
  CLK        input   1      rising-edge clock
  RESET_N    input   1      asynchronous active-low reset
  CLR        input   1      synchronous clear
  TGT_BIT    input   1      desired next Q of the driven JK flip-flop
  TGT_VALID  input   1      TGT_BIT valid
  TGT_READY  output  1      FIFO can accept TGT_BIT
  Q_FB       input   1      Q fed back from the driven JK flip-flop
  J          output  1      J drive, registered
  K          output  1      K drive, registered
  MISMATCH   output  1      one-cycle pulse, checked Q differed from target
  ERR_CNT    output  CNT_W  saturating mismatch count
  DONE_CNT   output  CNT_W  saturating checked-item count
  BUSY       output  1      FSM not IDLE or FIFO non-empty
REQ-003 One clock; reset is asynchronous and active-low, ports named CLK and RESET_N.

Function
REQ-004 Push SHALL occur on an edge where TGT_VALID && TGT_READY; TGT_READY SHALL equal !full, combinationally from the registered occupancy.
REQ-005 Push and pop on the same edge SHALL both take effect, occupancy unchanged; TGT_BIT order SHALL be preserved.
REQ-006 FSM states SHALL be IDLE, DRIVE, CHECK.
REQ-007 IDLE: on an edge with FIFO non-empty -> pop head into tgt_r, load J/K per REQ-009 from Q_FB sampled at that edge, go DRIVE; else stay, J=K=0.
REQ-008 DRIVE lasts exactly one cycle; its closing edge SHALL set J=K=0 and go CHECK.
REQ-009 Excitation (Q_FB -> tgt_r: J,K), x = DC_ONE: 0->0: 0,x; 0->1: 1,x; 1->0: x,1; 1->1: x,0.
REQ-010 CHECK closing edge: MISMATCH <= (Q_FB != tgt_r) for one cycle; DONE_CNT += 1; ERR_CNT += 1 on mismatch.
REQ-011 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-012 CHECK closing edge with FIFO non-empty SHALL pop and go directly to DRIVE (per REQ-007 excitation); throughput one item per 2 cycles; empty -> IDLE.
REQ-013 MISMATCH SHALL be 0 on all edges other than REQ-010.
REQ-014 CLR SHALL on its edge flush the FIFO, force IDLE, J=K=0, MISMATCH=0, both counters 0; CLR SHALL override a same-edge push, pop or count.
REQ-015 BUSY SHALL be 1 whenever state != IDLE or occupancy != 0.

Reset
REQ-016 RESET_N low SHALL immediately, without a clock, set: FIFO empty, state IDLE, J=0, K=0, MISMATCH=0, ERR_CNT=0, DONE_CNT=0, TGT_READY=1, BUSY=0.
REQ-017 Reset asserted mid-item SHALL discard that item and FIFO contents; no counter update for it.
REQ-018 Normal operation SHALL start on the first rising edge after RESET_N deasserts.

Verification
REQ-019 Bench SHALL model a JK flip-flop (hold/reset/set/toggle) fed by J/K with Q to Q_FB, and cover:
  - DC_ONE=0, Q=0, push 1,0,0,1 -> J/K 1/0, 0/1, 0/0, 1/0 in DRIVE; final Q=1; DONE_CNT=4, ERR_CNT=0, MISMATCH never high.
  - DC_ONE=1, same sequence -> J/K 1/1, 1/1, 0/1, 1/1; same Q path and counts.
  - TGT_VALID held high with 6 items, DEPTH=4 -> TGT_READY low while full, no loss or reorder, 2-cycle spacing between DRIVE cycles, BUSY falls after last CHECK.
  - Q_FB forced 0, target 1 -> MISMATCH one-cycle pulse at CHECK edge, ERR_CNT=1; CNT_W=2, 5 mismatches -> ERR_CNT=3.
  - CLR during DRIVE with 2 items queued -> next edge IDLE, J=K=0, counters 0, FIFO empty, TGT_READY=1.
  - RESET_N low mid-CHECK between clock edges -> outputs per REQ-016 immediately; after release, new item processed normally.
